// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Parametrised UART receiver with mid-bit majority voting, false-start
//   rejection, parity/stop checking and assembly of FRAME_BYTES characters
//   into one wide word. Sits between the board RXD pin and the command
//   decoder.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rxd          asynchronous serial input, idle high
//   rx_en        receive enable, honoured only while idle
//   byte_data    last good character
//   byte_valid   1-cycle strobe per good character
//   frame_data   last assembled frame, first character in the LSBs
//   frame_valid  1-cycle strobe, coincident with the final byte_valid
//   parity_err   1-cycle strobe on parity mismatch (stop bit good)
//   frame_err    1-cycle strobe when a stop bit is sampled low
//   timeout_err  1-cycle strobe when a partial frame is dropped on gap timeout
//   busy         high while the receive state machine is not idle
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a start edge; runs the inter-character gap timer
// START   | timing the start bit; aborts if the voted start bit is high
// DATA    | shifting in DATA_BITS voted bits, LSB first
// PARITY  | sampling and checking the parity bit
// STOP    | sampling STOP_BITS stop bits; leaves at the last mid-bit vote

module uart_rx_framer #(
  parameter int CLK_DIV     = 1216,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FRAME_BYTES = 6,
  parameter int GAP_BITS    = 20
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rxd,
  input  logic                             rx_en,
  output logic [DATA_BITS-1:0]             byte_data,
  output logic                             byte_valid,
  output logic [FRAME_BYTES*DATA_BITS-1:0] frame_data,
  output logic                             frame_valid,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             timeout_err,
  output logic                             busy
);

  localparam int CNT_W     = $clog2(CLK_DIV);
  localparam int MID       = CLK_DIV / 2;
  localparam int BIT_W     = $clog2(DATA_BITS + 1);
  localparam int IDX_W     = $clog2(FRAME_BYTES + 1);
  localparam int FRAME_W   = FRAME_BYTES * DATA_BITS;
  localparam int GAP_LIMIT = GAP_BITS * CLK_DIV;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(MID + 1);
  localparam logic [BIT_W-1:0] BIT_DATA   = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_STOP   = BIT_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FRAME_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   samp0_q, samp0_d;
  logic                   samp1_q, samp1_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   stop_bad_q, stop_bad_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_W-1:0]     asm_q, asm_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [DATA_BITS-1:0]   byte_data_q, byte_data_d;
  logic                   byte_valid_q, byte_valid_d;
  logic [FRAME_W-1:0]     frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   fall_edge;
  logic                   cnt_wrap;
  logic                   at_vote;
  logic                   vote;
  logic                   stop_bad_now;
  logic                   par_calc;
  logic [FRAME_W-1:0]     asm_next;

  assign fall_edge = hist_q & ~sync2_q;
  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign at_vote   = (cnt_q == CNT_MID_P1);
  // Third sample is the live synchronised value at MID+1.
  assign vote      = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);
  assign par_calc  = ^{shift_q, vote};

  always_comb begin
    sync1_d       = rxd;
    sync2_d       = sync1_q;
    hist_d        = sync2_q;
    state_d       = state_q;
    cnt_d         = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    bit_d         = bit_q;
    samp0_d       = (cnt_q == CNT_MID_M1) ? sync2_q : samp0_q;
    samp1_d       = (cnt_q == CNT_MID)    ? sync2_q : samp1_q;
    shift_d       = shift_q;
    par_bad_d     = par_bad_q;
    stop_bad_d    = stop_bad_q;
    idx_d         = idx_q;
    asm_d         = asm_q;
    gap_d         = '0;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    stop_bad_now  = stop_bad_q | ~vote;

    asm_next = asm_q;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        asm_next[i*DATA_BITS +: DATA_BITS] = shift_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_en) begin
          idx_d = '0;
        end else if (fall_edge) begin
          state_d    = ST_START;
          bit_d      = '0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end else if (idx_q != '0) begin
          if (gap_q == GAP_LAST) begin
            timeout_err_d = 1'b1;
            idx_d         = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;
        end else if (cnt_wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end

      ST_DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_W'(1);
        end
        if (cnt_wrap && bit_q == BIT_DATA) begin
          state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          bit_d   = '0;
        end
      end

      ST_PARITY: begin
        if (at_vote) begin
          par_bad_d = (PARITY == 1) ? ~par_calc : par_calc;
        end
        if (cnt_wrap) begin
          state_d = ST_STOP;
          bit_d   = '0;
        end
      end

      ST_STOP: begin
        if (at_vote) begin
          stop_bad_d = stop_bad_now;
          if (bit_q == BIT_STOP) begin
            // Leave mid-bit so the next start edge is never missed.
            state_d = ST_IDLE;
            if (stop_bad_now) begin
              frame_err_d = 1'b1;
              idx_d       = '0;
            end else if (par_bad_q) begin
              parity_err_d = 1'b1;
              idx_d        = '0;
            end else begin
              byte_data_d  = shift_q;
              byte_valid_d = 1'b1;
              asm_d        = asm_next;
              if (idx_q == IDX_LAST) begin
                frame_data_d  = asm_next;
                frame_valid_d = 1'b1;
                idx_d         = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      hist_q        <= 1'b1;
      cnt_q         <= '0;
      bit_q         <= '0;
      samp0_q       <= 1'b1;
      samp1_q       <= 1'b1;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      stop_bad_q    <= 1'b0;
      idx_q         <= '0;
      asm_q         <= '0;
      gap_q         <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      hist_q        <= hist_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      samp0_q       <= samp0_d;
      samp1_q       <= samp1_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      stop_bad_q    <= stop_bad_d;
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      gap_q         <= gap_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
